cache_refill_controller: RTL

//  Miss/refill controller between the two-way data cache and data memory.
//  - Load hits: returns cache data with zero added latency.
//  - Load misses: stalls the pipeline, fetches the word over a req/ack handshake, writes it into the cache, then returns it.
//  - Stores: write-through to memory, with no allocate on miss.
//  - A watchdog flags memory that never acknowledges.

---
 rtl/cache_refill_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cache_refill_controller.sv
// Miss/refill controller between a two-way data cache and data memory.
// Load hits pass straight through; misses refill over a req/ack handshake; stores write through.
module cache_refill_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  stall_o,
  output logic                  fill_we_o,
  output logic [DATA_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  // state  | meaning
  // IDLE   | accept requests; load hits answered combinationally
  // RD_MEM | memory read outstanding
  // WR_MEM | memory write-through outstanding
  // FILL   | one-cycle cache write strobe
  // DONE   | release pipeline, present captured data
  typedef enum logic [2:0] {IDLE, RD_MEM, WR_MEM, FILL, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                  hit_q, we_q, err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  timeout;
  logic                  load_hit;

  // Last permitted request cycle: counter started at 0 on entry.
  assign timeout  = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign load_hit = cpu_req_i && !cpu_we_i && cache_hit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req_i && !load_hit) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            hit_q   <= cache_hit_i;
            we_q    <= cpu_we_i;
            rdata_q <= '0;
            cnt_q   <= '0;
          end
        end
        RD_MEM, WR_MEM: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack_i) begin
            if (state == RD_MEM) rdata_q <= mem_rdata_i;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_o     = 1'b0;
    cpu_rdata_o = '0;
    fill_we_o   = 1'b0;
    fill_addr_o = '0;
    fill_data_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    case (state)
      IDLE: begin
        if (load_hit) begin
          cpu_rdata_o = cache_rdata_i;
        end else if (cpu_req_i) begin
          stall_o   = 1'b1;
          state_nxt = cpu_we_i ? WR_MEM : RD_MEM;
        end
      end
      RD_MEM: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i)    state_nxt = FILL;
        else if (timeout) state_nxt = DONE;
      end
      WR_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        stall_o   = 1'b1;
        // No allocate on a store miss: only a store hit refreshes the cache.
        if (mem_ack_i)    state_nxt = hit_q ? FILL : DONE;
        else if (timeout) state_nxt = DONE;
      end
      FILL: begin
        fill_we_o   = 1'b1;
        fill_addr_o = addr_q;
        fill_data_o = we_q ? wdata_q : rdata_q;
        stall_o     = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        cpu_rdata_o = rdata_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;

endmodule
